uart_transmitter_fifo: RTL and testbench
========================================

# uart_transmitter_fifo

Parametrised successor to the ice40 UART transmitter. Frame format is configurable: data width, optional parity, one or two stop bits. A small FIFO buffers outgoing words behind a valid/ready handshake, so frames go out back-to-back with no idle gap. The block sits between on-chip producers (host interface, debug streamers) and the board TX pin.

## Interface
- `ClocksPerBaud`, default 2: clock cycles per bit; must be ≥ 2.
- `DataBits`, default 8: data bits per frame, range 5..9.
- `ParityMode`, default 0: 0 = none, 1 = even, 2 = odd.
- `StopBits`, default 1: 1 or 2.
- `FifoDepth`, default 4: entries; must be a power of two and ≥ 2.
- `clk`  in  1: clock.
- `rst_n`  in  1: asynchronous, active-low reset.
- `tx_data`  in  DataBits: word to send; LSB is transmitted first.
- `tx_valid`  in  1: producer offers `tx_data`.
- `tx_ready`  out  1: FIFO not full.
- `tx_done_out`  out  1: one-cycle pulse when a frame's final stop bit completes.
- `tx_busy_out`  out  1: high while a frame is on the wire.
- `fifo_count_out`  out  $clog2(FifoDepth+1): current number of FIFO entries.
- `tx_out`  out  1: serial line; idles high.

## Operation
- Push happens on a rising edge with `tx_valid && tx_ready`. When full, `tx_ready` is 0 even if a pop occurs in the same cycle (no push-through). There is no bypass: every word passes through the FIFO.
- Frame layout: start bit (0), DataBits data bits LSB first, then a parity bit if enabled, then StopBits stop bits (1).
  - Even parity: XOR of the data bits.
  - Odd parity: the inverse of that XOR.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE → START when the FIFO is non-empty. The entry is popped on this same edge and latched into a shift register together with its parity.
  - START → DATA after one baud.
  - DATA repeats for DataBits bauds, driven by a bit counter, then goes to PARITY if enabled, otherwise to STOP.
  - PARITY → STOP after one baud.
  - STOP lasts StopBits bauds. At the end of STOP: if the FIFO is non-empty, go directly to START and pop; otherwise go to IDLE.
- Baud counter: counts 0..ClocksPerBaud-1. The bit advances when the counter reaches ClocksPerBaud-1.
- `tx_busy_out` is high in START, DATA, PARITY and STOP. It stays high across back-to-back frames.
- `tx_out` is driven from a register. It is forced to 1 in IDLE.
- `fifo_count_out` changes by +1 on a push, by −1 on a pop, and is unchanged when both happen in the same cycle.
- Invalid parameters cause an `initial` block to print an `ERROR:` message and call `$finish`.

## Timing
- Reset values:
  - `tx_out` = 1
  - `tx_ready` = 1
  - `tx_done_out` = 0
  - `tx_busy_out` = 0
  - `fifo_count_out` = 0
- Reset clears the FIFO, the FSM and the counters.
- Reset mid-frame: `tx_out` returns to 1 asynchronously. The partial frame is abandoned and no done pulse is produced.
- Latency: a push at edge E0 into an empty FIFO with the FSM in IDLE makes `tx_out` fall at edge E1, one cycle later.
- Every bit is held for exactly ClocksPerBaud cycles.
- Frame length is F = (1 + DataBits + (ParityMode != 0) + StopBits) × ClocksPerBaud cycles.
- `tx_done_out` is high during the last cycle of the final stop bit. That is cycle F−1 counted from the start-bit falling edge, i.e. F−1 cycles after the fall.
- Back-to-back frames: the next start bit begins on the cycle immediately after the done pulse. Start-to-start spacing is exactly F cycles.
- `tx_ready` reasserts on the cycle after the pop that frees a full FIFO.

## Structure
- Shared include `xls/uncore_rtl/ice40/uart_defs.inc` holds:
  - parity-mode encodings (`ParityNone`, `ParityEven`, `ParityOdd`);
  - FSM state encodings.
- Sub-module `uart_fifo`: a synchronous FIFO with parameters Width and Depth. It has push, pop, full, empty and count ports. Pointers are `$clog2(Depth)` wide plus one wrap bit.
- The top level holds the FSM, the baud counter, the bit counter, the shift register and the parity logic.

## Test plan
- ClocksPerBaud=4, 8N1, push 0x55 → `tx_out` falls 1 cycle after the push. The line shows 0,1,0,1,0,1,0,1,0,1 with 4 cycles per bit. `tx_done_out` pulses 39 cycles after the fall.
- 8E1, push 0x55 → parity bit 0, F=44 cycles. 8O1, push 0x55 → parity bit 1.
- 7O2, push 0x41 → data 1,0,0,0,0,0,1, then parity 1, then two stop bits. F=11 bauds. `tx_busy_out` is high throughout.
- FifoDepth=4, push 5 words back-to-back at ClocksPerBaud=2:
  - after the first pop, the FIFO refills to 4 and `tx_ready` drops;
  - `tx_ready` rises one cycle after the next pop;
  - frames go out with no idle gap and 20-cycle start-to-start spacing;
  - `fifo_count_out` tracks correctly.
- Push 0xA5, then assert `rst_n`=0 mid-data → `tx_out`=1 immediately and `fifo_count_out`=0. After release, the line stays idle high for 50 cycles with no done pulse.
- Push on the exact cycle of `tx_done_out` with an empty FIFO → the next start bit begins one cycle later than the back-to-back case. That gives an F+1-cycle start-to-start spacing, with a single idle-high cycle between the frames.

Source files
------------

// File: rtl/uart_transmitter_fifo_pkg.sv
// Shared encodings for the FIFO-buffered UART transmitter: parity modes,
// FSM states and a parameter sanity helper.
package uart_transmitter_fifo_pkg;

  localparam int ParityNone = 0;
  localparam int ParityEven = 1;
  localparam int ParityOdd  = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } tx_state_e;

  function automatic bit is_pow2(input int v);
    return (v > 0) && ((v & (v - 1)) == 0);
  endfunction

endpackage

// File: rtl/uart_transmitter_fifo_fifo.sv
// Synchronous first-word-fall-through FIFO; pointers carry one extra wrap
// bit so full and empty are told apart without a separate counter.
module uart_fifo #(
  parameter int Width = 8,
  parameter int Depth = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push_i,
  input  logic [Width-1:0]       wdata_i,
  input  logic                   pop_i,
  output logic [Width-1:0]       rdata_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(Depth):0] count_o
);

  localparam int PtrW = $clog2(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW:0]    wr_ptr_q, wr_ptr_d;
  logic [PtrW:0]    rd_ptr_q, rd_ptr_d;
  logic             do_push, do_pop;

  assign empty_o  = (wr_ptr_q == rd_ptr_q);
  assign full_o   = (wr_ptr_q[PtrW] != rd_ptr_q[PtrW]) &&
                    (wr_ptr_q[PtrW-1:0] == rd_ptr_q[PtrW-1:0]);
  assign count_o  = wr_ptr_q - rd_ptr_q;

  // Push is gated by full alone, so a simultaneous pop never frees a slot early.
  assign do_push  = push_i && !full_o;
  assign do_pop   = pop_i && !empty_o;
  assign wr_ptr_d = wr_ptr_q + {{PtrW{1'b0}}, do_push};
  assign rd_ptr_d = rd_ptr_q + {{PtrW{1'b0}}, do_pop};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q[PtrW-1:0]] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[rd_ptr_q[PtrW-1:0]];

endmodule

// File: rtl/uart_transmitter_fifo.sv
// UART transmitter with configurable frame format fed from a small FIFO;
// frames leave back-to-back while words are queued.
module uart_transmitter_fifo
  import uart_transmitter_fifo_pkg::*;
#(
  parameter int ClocksPerBaud = 2,
  parameter int DataBits      = 8,
  parameter int ParityMode    = 0,
  parameter int StopBits      = 1,
  parameter int FifoDepth     = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [DataBits-1:0]            tx_data,
  input  logic                           tx_valid,
  output logic                           tx_ready,
  output logic                           tx_done_out,
  output logic                           tx_busy_out,
  output logic [$clog2(FifoDepth+1)-1:0] fifo_count_out,
  output logic                           tx_out
);

  localparam int BaudW = $clog2(ClocksPerBaud);
  localparam int BitW  = $clog2(DataBits);
  localparam logic [BaudW-1:0] BaudLast  = BaudW'(ClocksPerBaud - 1);
  localparam logic [BitW-1:0]  DataLast  = BitW'(DataBits - 1);
  localparam logic [BitW-1:0]  StopLast  = BitW'(StopBits - 1);
  localparam bit               HasParity = (ParityMode != ParityNone);

  if (!(ClocksPerBaud >= 2 && DataBits >= 5 && DataBits <= 9 &&
        ParityMode >= 0 && ParityMode <= 2 && (StopBits == 1 || StopBits == 2) &&
        FifoDepth >= 2 && is_pow2(FifoDepth))) begin : g_param_error
    $fatal(1, "ERROR: uart_transmitter_fifo: invalid parameter set");
  end

  tx_state_e          state_q, state_d;
  logic [BaudW-1:0]   baud_q, baud_d;
  logic [BitW-1:0]    bit_q, bit_d;
  logic [DataBits-1:0] shift_q, shift_d;
  logic               parity_q, parity_d;
  logic               tx_q, tx_d;

  logic               fifo_full, fifo_empty, launch;
  logic [DataBits-1:0] fifo_rdata;
  logic               raw_parity, data_parity, baud_last;

  uart_fifo #(
    .Width (DataBits),
    .Depth (FifoDepth)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (tx_valid),
    .wdata_i (tx_data),
    .pop_i   (launch),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count_out)
  );

  assign raw_parity  = ^fifo_rdata;
  assign data_parity = (ParityMode == ParityOdd) ? ~raw_parity : raw_parity;
  assign baud_last   = (baud_q == BaudLast);

  always_comb begin
    state_d  = state_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    parity_d = parity_q;
    tx_d     = tx_q;
    launch   = 1'b0;
    // tx_d always reflects the bit of the state being entered, keeping the line registered.
    case (state_q)
      ST_IDLE: begin
        tx_d   = 1'b1;
        launch = !fifo_empty;
      end
      ST_START: begin
        if (baud_last) begin
          state_d = ST_DATA;
          bit_d   = '0;
          tx_d    = shift_q[0];
        end
      end
      ST_DATA: begin
        if (baud_last) begin
          if (bit_q == DataLast) begin
            bit_d = '0;
            if (HasParity) begin
              state_d = ST_PARITY;
              tx_d    = parity_q;
            end else begin
              state_d = ST_STOP;
              tx_d    = 1'b1;
            end
          end else begin
            bit_d   = bit_q + BitW'(1);
            shift_d = shift_q >> 1;
            tx_d    = shift_q[1];
          end
        end
      end
      ST_PARITY: begin
        if (baud_last) begin
          state_d = ST_STOP;
          bit_d   = '0;
          tx_d    = 1'b1;
        end
      end
      ST_STOP: begin
        if (baud_last) begin
          if (bit_q == StopLast) begin
            launch = !fifo_empty;
            if (fifo_empty) begin
              state_d = ST_IDLE;
              tx_d    = 1'b1;
            end
          end else begin
            bit_d = bit_q + BitW'(1);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        tx_d    = 1'b1;
      end
    endcase

    if (state_q == ST_IDLE || baud_last) begin
      baud_d = '0;
    end else begin
      baud_d = baud_q + BaudW'(1);
    end

    if (launch) begin
      state_d  = ST_START;
      shift_d  = fifo_rdata;
      parity_d = data_parity;
      tx_d     = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      parity_q <= 1'b0;
      tx_q     <= 1'b1;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      parity_q <= parity_d;
      tx_q     <= tx_d;
    end
  end

  assign tx_out      = tx_q;
  assign tx_ready    = !fifo_full;
  assign tx_busy_out = (state_q != ST_IDLE);
  assign tx_done_out = (state_q == ST_STOP) && baud_last && (bit_q == StopLast);

endmodule

// File: tb/tb_uart_transmitter_fifo.sv
// Bench for uart_transmitter_fifo: five frame configurations side by side, a
// per-instance line monitor fed by a scoreboard, and scenario tasks for timing.
module tb_uart_transmitter_fifo;

  localparam int NI = 5;
  localparam int CPB [NI] = '{4, 4, 4, 3, 2};
  localparam int DB  [NI] = '{8, 8, 8, 7, 8};
  localparam int PM  [NI] = '{0, 1, 2, 2, 0};
  localparam int SB  [NI] = '{1, 1, 1, 2, 1};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rst_n;
  logic [NI-1:0]       valid;
  logic [NI-1:0][7:0]  data;
  wire  [NI-1:0]       ready, done, busy, txo;
  wire  [NI-1:0][2:0]  cnt;
  wire                 unused_bit = data[3][7];

  int n_vec = 0;
  int n_bad = 0;
  logic [7:0] sb [NI][$];

  for (genvar gi = 0; gi < NI; gi++) begin : g_dut
    localparam int Cpb = CPB[gi];
    localparam int Db  = DB[gi];
    localparam int Pm  = PM[gi];
    localparam int Sb  = SB[gi];
    localparam int Nb  = 1 + Db + ((Pm != 0) ? 1 : 0) + Sb;
    localparam int F   = Nb * Cpb;

    uart_transmitter_fifo #(
      .ClocksPerBaud (Cpb),
      .DataBits      (Db),
      .ParityMode    (Pm),
      .StopBits      (Sb),
      .FifoDepth     (4)
    ) u_dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .tx_data        (data[gi][Db-1:0]),
      .tx_valid       (valid[gi]),
      .tx_ready       (ready[gi]),
      .tx_done_out    (done[gi]),
      .tx_busy_out    (busy[gi]),
      .fifo_count_out (cnt[gi]),
      .tx_out         (txo[gi])
    );

    logic [7:0] mw;
    logic       mpar;
    logic       mbits [16];
    logic       abort;

    // Line monitor: a falling line while idle starts a frame, checked cycle by cycle.
    initial begin
      forever begin
        @(negedge clk);
        if (rst_n === 1'b1 && txo[gi] === 1'b0) begin
          n_vec++;
          if (sb[gi].size() == 0) begin
            n_bad++;
            $display("FAIL frame%0d_start got start bit required no frame (scoreboard empty)", gi);
          end else begin
            mw   = sb[gi].pop_front();
            mpar = 1'b0;
            for (int i = 0; i < Db; i++) mpar ^= mw[i];
            if (Pm == 2) mpar = ~mpar;
            mbits[0] = 1'b0;
            for (int i = 0; i < Db; i++) mbits[1 + i] = mw[i];
            if (Pm != 0) mbits[1 + Db] = mpar;
            for (int s = 0; s < Sb; s++) mbits[Nb - Sb + s] = 1'b1;
            abort = 1'b0;
            for (int c = 0; c < F && !abort; c++) begin
              if (c > 0) @(negedge clk);
              if (rst_n !== 1'b1) begin
                abort = 1'b1;
              end else begin
                n_vec++;
                if (txo[gi] !== mbits[c / Cpb]) begin
                  n_bad++;
                  $display("FAIL frame%0d_line word=%h cycle=%0d got %b required %b",
                           gi, mw, c, txo[gi], mbits[c / Cpb]);
                end
                n_vec++;
                if (busy[gi] !== 1'b1) begin
                  n_bad++;
                  $display("FAIL frame%0d_busy cycle=%0d got %b required 1", gi, c, busy[gi]);
                end
                n_vec++;
                if (done[gi] !== (c == F - 1)) begin
                  n_bad++;
                  $display("FAIL frame%0d_done cycle=%0d got %b required %b",
                           gi, c, done[gi], (c == F - 1));
                end
              end
            end
            if (!abort) $display("frame%0d word=%h checked over %0d cycles", gi, mw, F);
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired before the bench finished");
    $fatal(1, "watchdog");
  end

  task automatic push(input int k, input logic [7:0] w);
    int guard = 0;
    @(negedge clk);
    data[k]  = w;
    valid[k] = 1'b1;
    while (ready[k] !== 1'b1 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    n_vec++;
    if (ready[k] !== 1'b1) begin
      n_bad++;
      $display("FAIL push_ready dut=%0d got %b required 1", k, ready[k]);
    end else begin
      @(posedge clk);
      sb[k].push_back(w);
      $display("push dut=%0d word=%h", k, w);
    end
  endtask

  task automatic release_valid(input int k);
    @(negedge clk);
    valid[k] = 1'b0;
  endtask

  task automatic wait_fall(input int k, input int budget, output int waited);
    waited = 0;
    while (txo[k] !== 1'b0 && waited < budget) begin
      @(negedge clk);
      waited++;
    end
  endtask

  task automatic wait_done(input int k, input int budget, output int waited);
    waited = 0;
    while (done[k] !== 1'b1 && waited < budget) begin
      @(negedge clk);
      waited++;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    valid = '0;
    data  = '0;
    repeat (3) @(negedge clk);
    for (int k = 0; k < NI; k++) begin
      n_vec++;
      if (txo[k] !== 1'b1 || ready[k] !== 1'b1 || done[k] !== 1'b0 ||
          busy[k] !== 1'b0 || cnt[k] !== 3'd0) begin
        n_bad++;
        $display("FAIL reset_state dut=%0d got tx=%b ready=%b done=%b busy=%b count=%0d required 1 1 0 0 0",
                 k, txo[k], ready[k], done[k], busy[k], cnt[k]);
      end
    end
    $display("reset checked on %0d instances", NI);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_8n1;
    int w, d;
    push(0, 8'h55);
    release_valid(0);
    n_vec++;
    if (txo[0] !== 1'b1 || cnt[0] !== 3'd1 || busy[0] !== 1'b0) begin
      n_bad++;
      $display("FAIL 8n1_after_push got tx=%b count=%0d busy=%b required 1 1 0", txo[0], cnt[0], busy[0]);
    end
    wait_fall(0, 10, w);
    n_vec++;
    if (w != 1) begin n_bad++; $display("FAIL 8n1_latency got %0d required 1", w); end
    n_vec++;
    if (cnt[0] !== 3'd0) begin n_bad++; $display("FAIL 8n1_pop_count got %0d required 0", cnt[0]); end
    wait_done(0, 100, d);
    n_vec++;
    if (d != 39) begin n_bad++; $display("FAIL 8n1_done_delay got %0d required 39", d); end
    @(negedge clk);
    n_vec++;
    if (txo[0] !== 1'b1 || busy[0] !== 1'b0) begin
      n_bad++;
      $display("FAIL 8n1_idle_after got tx=%b busy=%b required 1 0", txo[0], busy[0]);
    end
  endtask

  task automatic test_parity;
    int w, d;
    for (int k = 1; k <= 2; k++) begin
      push(k, 8'h55);
      release_valid(k);
      wait_fall(k, 10, w);
      n_vec++;
      if (w != 1) begin n_bad++; $display("FAIL parity_latency dut=%0d got %0d required 1", k, w); end
      repeat (36) @(negedge clk);
      n_vec++;
      if (txo[k] !== ((k == 2) ? 1'b1 : 1'b0)) begin
        n_bad++;
        $display("FAIL parity_bit dut=%0d got %b required %b", k, txo[k], (k == 2));
      end
      wait_done(k, 100, d);
      n_vec++;
      if (d != 7) begin n_bad++; $display("FAIL parity_frame_len dut=%0d got %0d required 7", k, d); end
      @(negedge clk);
    end
  endtask

  task automatic test_7o2;
    int w, d;
    push(3, 8'h41);
    release_valid(3);
    wait_fall(3, 10, w);
    n_vec++;
    if (w != 1) begin n_bad++; $display("FAIL 7o2_latency got %0d required 1", w); end
    wait_done(3, 100, d);
    n_vec++;
    if (d != 32) begin n_bad++; $display("FAIL 7o2_done_delay got %0d required 32", d); end
    @(negedge clk);
    n_vec++;
    if (busy[3] !== 1'b0) begin n_bad++; $display("FAIL 7o2_busy_after got %b required 0", busy[3]); end
  endtask

  task automatic test_back_to_back;
    logic [2:0] exp_cnt [5] = '{3'd1, 3'd3, 3'd2, 3'd1, 3'd0};
    fork
      begin
        for (int i = 0; i < 5; i++) push(4, 8'($urandom_range(0, 255)));
        release_valid(4);
        n_vec++;
        if (cnt[4] !== 3'd4 || ready[4] !== 1'b0) begin
          n_bad++;
          $display("FAIL b2b_refill got count=%0d ready=%b required 4 0", cnt[4], ready[4]);
        end
      end
      begin
        int w, d;
        wait_fall(4, 20, w);
        for (int i = 0; i < 5; i++) begin
          n_vec++;
          if (cnt[4] !== exp_cnt[i] || ready[4] !== 1'b1) begin
            n_bad++;
            $display("FAIL b2b_start%0d got count=%0d ready=%b required %0d 1",
                     i, cnt[4], ready[4], exp_cnt[i]);
          end
          wait_done(4, 40, d);
          n_vec++;
          if (d != 19) begin n_bad++; $display("FAIL b2b_done%0d got %0d required 19", i, d); end
          if (i == 0) begin
            n_vec++;
            if (cnt[4] !== 3'd4 || ready[4] !== 1'b0) begin
              n_bad++;
              $display("FAIL b2b_full_before_pop got count=%0d ready=%b required 4 0", cnt[4], ready[4]);
            end
          end
          if (i < 4) begin
            wait_fall(4, 5, w);
            n_vec++;
            if (w != 1) begin n_bad++; $display("FAIL b2b_gap%0d got %0d required 1", i, w); end
          end
        end
        @(negedge clk);
        n_vec++;
        if (txo[4] !== 1'b1 || busy[4] !== 1'b0) begin
          n_bad++;
          $display("FAIL b2b_idle_after got tx=%b busy=%b required 1 0", txo[4], busy[4]);
        end
      end
    join
  endtask

  task automatic test_reset_mid_frame;
    push(4, 8'hA5);
    push(4, 8'h3C);
    release_valid(4);
    repeat (4) @(negedge clk);
    n_vec++;
    if (txo[4] !== 1'b0) begin n_bad++; $display("FAIL midreset_data_bit got %b required 0", txo[4]); end
    #2 rst_n = 1'b0;
    #1;
    n_vec++;
    if (txo[4] !== 1'b1 || cnt[4] !== 3'd0 || busy[4] !== 1'b0 || done[4] !== 1'b0 || ready[4] !== 1'b1) begin
      n_bad++;
      $display("FAIL midreset_async got tx=%b count=%0d busy=%b done=%b ready=%b required 1 0 0 0 1",
               txo[4], cnt[4], busy[4], done[4], ready[4]);
    end
    sb[4].delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      n_vec++;
      if (txo[4] !== 1'b1 || done[4] !== 1'b0) begin
        n_bad++;
        $display("FAIL midreset_quiet cycle=%0d got tx=%b done=%b required 1 0", c, txo[4], done[4]);
      end
    end
    $display("reset mid-frame: line idle for 50 cycles after release");
  endtask

  task automatic test_push_on_done;
    int w, d;
    logic [7:0] w1;
    push(4, 8'hC3);
    release_valid(4);
    wait_fall(4, 10, w);
    wait_done(4, 40, d);
    n_vec++;
    if (d != 19) begin n_bad++; $display("FAIL pod_first_done got %0d required 19", d); end
    w1       = 8'h96;
    data[4]  = w1;
    valid[4] = 1'b1;
    n_vec++;
    if (ready[4] !== 1'b1) begin n_bad++; $display("FAIL pod_ready got %b required 1", ready[4]); end
    @(posedge clk);
    sb[4].push_back(w1);
    $display("push dut=4 word=%h on done cycle", w1);
    @(negedge clk);
    valid[4] = 1'b0;
    n_vec++;
    if (txo[4] !== 1'b1 || busy[4] !== 1'b0 || cnt[4] !== 3'd1) begin
      n_bad++;
      $display("FAIL pod_idle_gap got tx=%b busy=%b count=%0d required 1 0 1", txo[4], busy[4], cnt[4]);
    end
    @(negedge clk);
    n_vec++;
    if (txo[4] !== 1'b0 || busy[4] !== 1'b1) begin
      n_bad++;
      $display("FAIL pod_restart got tx=%b busy=%b required 0 1", txo[4], busy[4]);
    end
    wait_done(4, 40, d);
    n_vec++;
    if (d != 19) begin n_bad++; $display("FAIL pod_second_done got %0d required 19", d); end
    @(negedge clk);
  endtask

  task automatic test_drain;
    repeat (4) @(negedge clk);
    for (int k = 0; k < NI; k++) begin
      n_vec++;
      if (sb[k].size() != 0) begin
        n_bad++;
        $display("FAIL drain dut=%0d got %0d frames outstanding required 0", k, sb[k].size());
      end
    end
  endtask

  initial begin
    test_reset;
    test_8n1;
    test_parity;
    test_7o2;
    test_back_to_back;
    test_reset_mid_frame;
    test_push_on_done;
    test_drain;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
